bram_fifo_sync: RTL and testbench

Single-clock, first-word-fall-through FIFO built on the team's inferable dual-port block RAM (`bram_dp`). Port A of the RAM is the write side and port B is the read side. The RAM's registered port-B output drives the FIFO read data directly, so no extra output register is needed. The block sits directly upstream of stream consumers and turns the raw RAM into a valid/ready buffer with full throughput, one word per cycle in and out.

---
 rtl/bram_fifo_sync_pkg.sv | 7 +
 rtl/bram_dp.sv | 32 +++
 rtl/bram_fifo_sync.sv | 83 ++++++++
 tb/tb_bram_fifo_sync.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_sync_pkg.sv
// Shared defaults for the block-RAM backed synchronous FIFO.
package bram_fifo_sync_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 72;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/bram_dp.sv
// Inferable dual-port block RAM: port A read/write, port B registered read.
module bram_dp #(
    parameter int unsigned DATA_WIDTH = 72,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  a_clk,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_clk,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port A is read-first: a_dout returns the old contents on a write.
    always_ff @(posedge a_clk) begin
        if (a_wr) begin
            mem[a_addr] <= a_din;
        end
        a_dout <= mem[a_addr];
    end

    always_ff @(posedge b_clk) begin
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/bram_fifo_sync.sv
// First-word-fall-through synchronous FIFO; the RAM's registered port-B output is the read data.
module bram_fifo_sync
    import bram_fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic                  wr;
    logic                  pop;
    logic                  ram_wr;
    logic [CNT_W-1:0]      remain;
    logic [CNT_W-1:0]      count_next;
    logic [DATA_WIDTH-1:0] a_dout_unused;

    // Look one slot ahead on a pop so the next word is presented right after the edge.
    always_comb begin
        wr         = wr_en && !full;
        pop        = rd_en && rd_valid;
        ram_wr     = wr && !rst;
        remain     = count - CNT_W'(pop);
        count_next = remain + CNT_W'(wr);
        rd_addr_c  = pop ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count     <= count_next;
            full      <= count_next == CNT_W'(DEPTH);
            // A same-cycle write is not yet readable, so only older words keep rd_valid up.
            rd_valid  <= remain != '0;
            overflow  <= overflow | (wr_en & full);
            underflow <= underflow | (rd_en & ~rd_valid);
        end
    end

    bram_dp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .a_clk (clk),
        .a_wr  (ram_wr),
        .a_addr(wr_ptr),
        .a_din (wr_data),
        .a_dout(a_dout_unused),
        .b_clk (clk),
        .b_addr(rd_addr_c),
        .b_dout(rd_data)
    );

endmodule

// File: tb/tb_bram_fifo_sync.sv
// Scoreboard bench for bram_fifo_sync with a queue-based occupancy model (DEPTH=4, 8-bit words).
module tb_bram_fifo_sync;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    bram_fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: words are tracked as a queue; only words older than this cycle are readable.
    int            m_cnt   = 0;
    bit            m_valid = 0;
    bit            m_ovf   = 0;
    bit            m_udf   = 0;
    bit            armed   = 0;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_valid = 0;
            m_ovf   = 0;
            m_udf   = 0;
            exp_q.delete();
            armed   = 1;
        end else if (armed) begin
            bit acc;
            bit pp;
            acc = wr_en && (m_cnt < DEPTH);
            pp  = rd_en && m_valid;
            if (wr_en && m_cnt == DEPTH) m_ovf = 1;
            if (rd_en && !m_valid) m_udf = 1;
            m_valid = (m_cnt - int'(pp)) > 0;
            m_cnt   = m_cnt + int'(acc) - int'(pp);
            if (acc) exp_q.push_back(wr_data);
        end
    end

    // Monitor: compares status every cycle and the head word whenever one should be presented.
    always @(negedge clk) begin
        if (armed) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            chk("full", 32'(full), 32'(m_cnt == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
            if (!rst && m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rd_data: DUT presents %02h with no word outstanding at %0t", rd_data, $time);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
                    if (rd_en) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        int maxc;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);

        // Basic write then read
        cyc(1'b1, 8'hA1, 1'b0);
        chk("basic_not_yet_valid", 32'(rd_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("basic_data", 32'(rd_data), 32'hA1);
        chk("basic_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("basic_popped", 32'(rd_valid), 32'd0);

        // Fill to full, one rejected write, drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        cyc(1'b1, 8'h14, 1'b0);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_count_kept", 32'(count), 32'd4);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        chk("fill_drained", 32'(count), 32'd0);

        // Streaming across pointer wrap
        do_reset();
        maxc = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(i), 1'b1);
            if (int'(count) > maxc) maxc = int'(count);
        end
        chk("stream_count_le2", 32'(maxc <= 2), 32'd1);
        chk("stream_valid_held", 32'(rd_valid), 32'd1);
        repeat (3) cyc(1'b0, 8'h00, 1'b1);

        // Write and pop together while full
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        cyc(1'b1, 8'h24, 1'b1);
        chk("fullwp_count", 32'(count), 32'd3);
        chk("fullwp_overflow", 32'(overflow), 32'd1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);

        // Underflow then recovery
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_flag", 32'(underflow), 32'd1);
        chk("udf_count", 32'(count), 32'd0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("udf_readback", 32'(rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1);

        // Reset mid-operation with a write in the reset cycle
        cyc(1'b1, 8'hC0, 1'b0);
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b0);
        rst = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_flags", 32'({overflow, underflow}), 32'd0);
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("midrst_first", 32'(rd_data), 32'h77);
        cyc(1'b0, 8'h00, 1'b1);

        // Random traffic with shifting bias and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            int rp;
            wp = (blk % 2 == 0) ? 75 : 35;
            rp = (blk % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 60; i++) begin
                rst = ($urandom_range(0, 99) == 0);
                cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
            end
            rst = 1'b0;
        end

        rst = 1'b0;
        repeat (6) cyc(1'b0, 8'h00, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("end_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
